line_rasterizer: RTL and testbench

- Parametrised Bresenham line rasteriser for the framebuffer write path; draws any-octant line (x1,y1)-(x2,y2) as a stream of single-pixel writes.
- Latches all inputs on accept (start & ready), so inputs may change freely during a draw.
- Adds write-port backpressure, runtime colour, clipping to the active area, and first-pixel skip for polyline chaining.
- Sits between the plot controller and the framebuffer write arbiter.

---
 rtl/line_rasterizer_if.sv | 40 ++++
 rtl/line_rasterizer.sv | 142 ++++++++++++++
 tb/tb_line_rasterizer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/line_rasterizer_if.sv
// Bundle between the plot controller / framebuffer write arbiter and the
// line rasteriser.
//   master : drives the line request (x1,y1,x2,y2,color,skip_first,start)
//            and the framebuffer acceptance (write_ready); observes status
//            and the pixel write port.
//   slave  : the rasteriser; accepts the request and drives ready, done,
//            write_enable, write_addr, write_data.
interface line_rasterizer_if #(
    parameter int HOR_ACTIVE_PIXELS = 640,
    parameter int VER_ACTIVE_PIXELS = 480,
    parameter int WRITE_DATA_WIDTH  = 1
);
    localparam int X_WIDTH          = $clog2(HOR_ACTIVE_PIXELS);
    localparam int Y_WIDTH          = $clog2(VER_ACTIVE_PIXELS);
    localparam int WRITE_ADDR_WIDTH = $clog2(HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS);

    logic [X_WIDTH-1:0]          x1;
    logic [Y_WIDTH-1:0]          y1;
    logic [X_WIDTH-1:0]          x2;
    logic [Y_WIDTH-1:0]          y2;
    logic [WRITE_DATA_WIDTH-1:0] color;
    logic                        skip_first;
    logic                        start;
    logic                        ready;
    logic                        done;
    logic                        write_enable;
    logic                        write_ready;
    logic [WRITE_ADDR_WIDTH-1:0] write_addr;
    logic [WRITE_DATA_WIDTH-1:0] write_data;

    modport master (
        output x1, y1, x2, y2, color, skip_first, start, write_ready,
        input  ready, done, write_enable, write_addr, write_data
    );

    modport slave (
        input  x1, y1, x2, y2, color, skip_first, start, write_ready,
        output ready, done, write_enable, write_addr, write_data
    );
endinterface

// File: rtl/line_rasterizer.sv
// Bresenham line rasteriser: draws (x1,y1)-(x2,y2) in any octant as a stream
// of single-pixel framebuffer writes with backpressure, clipping to the
// active area and optional first-pixel skip for polyline chaining.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : line_rasterizer_if.slave (request, status, pixel write port)
//
// state | meaning
// IDLE  | ready for a new line; done pulses here for one cycle after a line
// SETUP | latched endpoints -> deltas, step directions, initial error
// DRAW  | present current pixel (or skip it), step on handshake
module line_rasterizer #(
    parameter int HOR_ACTIVE_PIXELS = 640,
    parameter int VER_ACTIVE_PIXELS = 480,
    parameter int WRITE_DATA_WIDTH  = 1
) (
    input  logic             clk,
    input  logic             rst,
    line_rasterizer_if.slave bus
);
    localparam int X_WIDTH          = $clog2(HOR_ACTIVE_PIXELS);
    localparam int Y_WIDTH          = $clog2(VER_ACTIVE_PIXELS);
    localparam int COORD_WIDTH      = (X_WIDTH > Y_WIDTH) ? X_WIDTH : Y_WIDTH;
    localparam int WRITE_ADDR_WIDTH = $clog2(HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS);
    localparam int EW               = COORD_WIDTH + 2;

    localparam logic [X_WIDTH:0] HOR_LIM = (X_WIDTH + 1)'(HOR_ACTIVE_PIXELS);
    localparam logic [Y_WIDTH:0] VER_LIM = (Y_WIDTH + 1)'(VER_ACTIVE_PIXELS);

    typedef enum logic [1:0] {IDLE, SETUP, DRAW} state_t;
    state_t state, state_nx;

    logic [X_WIDTH-1:0]          x1_q, x2_q, x_q;
    logic [Y_WIDTH-1:0]          y1_q, y2_q, y_q;
    logic [WRITE_DATA_WIDTH-1:0] color_q;
    logic                        skip_q, first_q, done_q;
    logic                        sx_neg_q, sy_neg_q;
    logic signed [EW-1:0]        dx_q, dy_q, err_q;

    logic                 accept, ready_c, write_enable_c;
    logic                 writable, step, last;
    logic                 step_x, step_y;
    logic signed [EW-1:0] dx_raw, dy_raw, dx_abs, dy_negabs, err_nx;
    logic signed [EW:0]   e2, dx_ext, dy_ext;

    assign dx_raw    = $signed(EW'(x2_q)) - $signed(EW'(x1_q));
    assign dy_raw    = $signed(EW'(y2_q)) - $signed(EW'(y1_q));
    assign dx_abs    = dx_raw[EW-1] ? -dx_raw : dx_raw;
    // dy is kept as -|y2-y1| so the step tests read exactly as Bresenham's.
    assign dy_negabs = dy_raw[EW-1] ? dy_raw : -dy_raw;

    assign e2     = $signed({err_q, 1'b0});
    assign dx_ext = {dx_q[EW-1], dx_q};
    assign dy_ext = {dy_q[EW-1], dy_q};
    assign step_x = (e2 >= dy_ext);
    assign step_y = (e2 <= dx_ext);
    // Both corrections come from the same old err/e2 pair.
    assign err_nx = err_q + (step_x ? dy_q : {EW{1'b0}}) + (step_y ? dx_q : {EW{1'b0}});

    assign last     = (x_q == x2_q) && (y_q == y2_q);
    assign writable = (state == DRAW) && ({1'b0, x_q} < HOR_LIM) && ({1'b0, y_q} < VER_LIM)
                      && !(first_q && skip_q);
    // Clipped or skipped pixels still take one cycle.
    assign step     = (state == DRAW) && (!writable || bus.write_ready);
    assign accept   = bus.start && (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx       = state;
        ready_c        = 1'b0;
        write_enable_c = 1'b0;
        case (state)
            IDLE: begin
                ready_c = 1'b1;
                if (bus.start) state_nx = SETUP;
            end
            SETUP: state_nx = DRAW;
            DRAW: begin
                write_enable_c = writable;
                if (step && last) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x1_q     <= '0;
            y1_q     <= '0;
            x2_q     <= '0;
            y2_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            color_q  <= '0;
            skip_q   <= 1'b0;
            first_q  <= 1'b0;
            done_q   <= 1'b0;
            sx_neg_q <= 1'b0;
            sy_neg_q <= 1'b0;
            dx_q     <= '0;
            dy_q     <= '0;
            err_q    <= '0;
        end else begin
            done_q <= step && last;
            if (accept) begin
                x1_q    <= bus.x1;
                y1_q    <= bus.y1;
                x2_q    <= bus.x2;
                y2_q    <= bus.y2;
                color_q <= bus.color;
                skip_q  <= bus.skip_first;
            end
            if (state == SETUP) begin
                dx_q     <= dx_abs;
                dy_q     <= dy_negabs;
                sx_neg_q <= dx_raw[EW-1];
                sy_neg_q <= dy_raw[EW-1];
                err_q    <= dx_abs + dy_negabs;
                x_q      <= x1_q;
                y_q      <= y1_q;
                first_q  <= 1'b1;
            end else if (step && !last) begin
                err_q   <= err_nx;
                first_q <= 1'b0;
                if (step_x) x_q <= sx_neg_q ? x_q - X_WIDTH'(1) : x_q + X_WIDTH'(1);
                if (step_y) y_q <= sy_neg_q ? y_q - Y_WIDTH'(1) : y_q + Y_WIDTH'(1);
            end
        end
    end

    assign bus.ready        = ready_c;
    assign bus.done         = done_q;
    assign bus.write_enable = write_enable_c;
    assign bus.write_data   = color_q;
    assign bus.write_addr   = WRITE_ADDR_WIDTH'(y_q) * WRITE_ADDR_WIDTH'(HOR_ACTIVE_PIXELS)
                              + WRITE_ADDR_WIDTH'(x_q);
endmodule

// File: tb/tb_line_rasterizer.sv
// Directed bench for line_rasterizer. Inputs change 1 ns after the rising
// edge; a negedge monitor logs handshaken writes, done pulses and accepts,
// each tagged with the number of the rising edge that ends the observed cycle.
module tb_line_rasterizer;
    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks = 0;
    int failures = 0;
    int ncyc = 0;
    int wr_a[$], wr_t[$], wr_d[$], done_t[$], done_ok[$], acc_t[$], exp_a[$];
    int we_n = 0;
    int hold_n = 0;
    int t0;

    always #5 clk = ~clk;

    line_rasterizer_if bus ();

    line_rasterizer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(negedge clk) begin
        ncyc = ncyc + 1;
        if (bus.write_enable) begin
            we_n = we_n + 1;
            if (int'(bus.write_addr) == 2565) hold_n = hold_n + 1;
            if (bus.write_ready) begin
                wr_a.push_back(int'(bus.write_addr));
                wr_t.push_back(ncyc + 1);
                wr_d.push_back(int'(bus.write_data));
            end
        end
        if (bus.done) begin
            done_t.push_back(ncyc + 1);
            done_ok.push_back(int'(bus.ready && !bus.write_enable));
        end
        if (bus.start && bus.ready && !rst) acc_t.push_back(ncyc + 1);
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr();
        wr_a.delete(); wr_t.delete(); wr_d.delete();
        done_t.delete(); done_ok.delete(); acc_t.delete(); exp_a.delete();
        we_n = 0;
        hold_n = 0;
    endtask

    task automatic launch(input int ax1, input int ay1, input int ax2, input int ay2,
                          input int c, input int s);
        bus.x1 = ax1[9:0];
        bus.y1 = ay1[8:0];
        bus.x2 = ax2[9:0];
        bus.y2 = ay2[8:0];
        bus.color = c[0];
        bus.skip_first = s[0];
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        t0 = (acc_t.size() > 0) ? acc_t[acc_t.size()-1] : -1000;
    endtask

    task automatic wait_done(input string tag, input int n);
        int i = 0;
        while (done_t.size() == 0 && i < n) begin
            tick(1);
            i++;
        end
        if (done_t.size() == 0) chk({tag, "_timeout"}, 0, 1);
        tick(3);
    endtask

    task automatic chk_seq(input string tag);
        chk({tag, "_count"}, wr_a.size(), exp_a.size());
        for (int i = 0; i < wr_a.size() && i < exp_a.size(); i++)
            chk($sformatf("%s_addr%0d", tag, i), wr_a[i], exp_a[i]);
    endtask

    task automatic chk_done(input string tag, input int exp_t);
        chk({tag, "_done_count"}, done_t.size(), 1);
        if (done_t.size() > 0) begin
            chk({tag, "_done_time"}, done_t[0], exp_t);
            chk({tag, "_done_idle"}, done_ok[0], 1);
        end
    endtask

    initial begin
        bus.x1 = '0; bus.y1 = '0; bus.x2 = '0; bus.y2 = '0;
        bus.color = '0; bus.skip_first = 1'b0; bus.start = 1'b0;
        bus.write_ready = 1'b1;
        tick(2);
        chk("rst_ready", int'(bus.ready), 1);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_we", int'(bus.write_enable), 0);
        chk("rst_addr", int'(bus.write_addr), 0);
        chk("rst_data", int'(bus.write_data), 0);
        rst = 1'b0;
        tick(2);

        // horizontal line, full throughput
        clr();
        launch(0, 0, 3, 0, 1, 0);
        chk("t1_accept", acc_t.size(), 1);
        chk("t1_ready_setup", int'(bus.ready), 0);
        wait_done("t1", 40);
        exp_a = '{0, 1, 2, 3};
        chk_seq("t1");
        for (int i = 0; i < wr_t.size(); i++) begin
            chk($sformatf("t1_time%0d", i), wr_t[i], t0 + 2 + i);
            chk($sformatf("t1_data%0d", i), wr_d[i], 1);
        end
        chk_done("t1", t0 + 6);

        // steep octant, inputs disturbed mid-draw
        clr();
        launch(5, 5, 3, 0, 0, 0);
        bus.x1 = 10'd17; bus.y1 = 9'd33; bus.x2 = 10'd200; bus.y2 = 9'd100;
        tick(2);
        bus.x1 = 10'd600; bus.y2 = 9'd7;
        wait_done("t2", 40);
        exp_a = '{3205, 2565, 1924, 1284, 643, 3};
        chk_seq("t2");
        if (wr_d.size() > 0) chk("t2_data", wr_d[0], 0);
        chk_done("t2", t0 + 8);

        // same line with a 3-cycle stall on the second pixel
        clr();
        launch(5, 5, 3, 0, 1, 0);
        tick(2);
        bus.write_ready = 1'b0;
        tick(3);
        bus.write_ready = 1'b1;
        wait_done("t3", 40);
        exp_a = '{3205, 2565, 1924, 1284, 643, 3};
        chk_seq("t3");
        chk("t3_we_cycles", we_n, 9);
        chk("t3_hold_cycles", hold_n, 4);
        chk_done("t3", t0 + 11);

        // right-edge clipping
        clr();
        launch(638, 0, 641, 0, 1, 0);
        wait_done("t4a", 40);
        exp_a = '{638, 639};
        chk_seq("t4a");
        if (wr_t.size() > 0) chk("t4a_first_time", wr_t[0], t0 + 2);
        chk_done("t4a", t0 + 6);

        // degenerate line, skipped
        clr();
        launch(7, 7, 7, 7, 1, 1);
        wait_done("t4b", 40);
        chk("t4b_count", wr_a.size(), 0);
        chk_done("t4b", t0 + 3);

        // degenerate line, written
        clr();
        launch(7, 7, 7, 7, 1, 0);
        wait_done("t4c", 40);
        exp_a = '{4487};
        chk_seq("t4c");
        chk_done("t4c", t0 + 3);

        // skip_first on a longer line
        clr();
        launch(0, 0, 3, 0, 1, 1);
        wait_done("t4d", 40);
        exp_a = '{1, 2, 3};
        chk_seq("t4d");
        chk_done("t4d", t0 + 6);

        // reset during the third pixel
        clr();
        launch(0, 0, 9, 9, 1, 0);
        tick(3);
        rst = 1'b1;
        tick(1);
        chk("t5_rst_we", int'(bus.write_enable), 0);
        chk("t5_rst_ready", int'(bus.ready), 1);
        chk("t5_rst_done", int'(bus.done), 0);
        chk("t5_rst_addr", int'(bus.write_addr), 0);
        rst = 1'b0;
        tick(6);
        exp_a = '{0, 641, 1282};
        chk_seq("t5");
        chk("t5_no_done", done_t.size(), 0);
        clr();
        launch(2, 1, 4, 2, 1, 0);
        wait_done("t5b", 40);
        exp_a = '{642, 1283, 1284};
        chk_seq("t5b");
        if (wr_t.size() > 0) chk("t5b_first_time", wr_t[0], t0 + 2);
        chk_done("t5b", t0 + 5);

        // start while busy is dropped
        clr();
        launch(0, 0, 3, 0, 1, 0);
        bus.x1 = 10'd9; bus.y1 = 9'd9; bus.x2 = 10'd20; bus.y2 = 9'd20;
        bus.start = 1'b1;
        tick(2);
        bus.start = 1'b0;
        wait_done("t6a", 40);
        chk("t6a_accepts", acc_t.size(), 1);
        exp_a = '{0, 1, 2, 3};
        chk_seq("t6a");

        // start held through done: back-to-back lines
        clr();
        launch(0, 0, 2, 0, 1, 0);
        bus.x1 = 10'd1; bus.y1 = 9'd1; bus.x2 = 10'd1; bus.y2 = 9'd3;
        bus.start = 1'b1;
        for (int i = 0; i < 30 && acc_t.size() < 2; i++) tick(1);
        bus.start = 1'b0;
        for (int i = 0; i < 30 && done_t.size() < 2; i++) tick(1);
        tick(3);
        chk("t6b_accepts", acc_t.size(), 2);
        chk("t6b_dones", done_t.size(), 2);
        exp_a = '{0, 1, 2, 641, 1281, 1921};
        chk_seq("t6b");
        if (acc_t.size() > 1 && done_t.size() > 0) chk("t6b_accept_at_done", acc_t[1], done_t[0]);
        if (wr_t.size() > 3 && done_t.size() > 0) chk("t6b_first_b_write", wr_t[3], done_t[0] + 2);
        if (done_t.size() > 0) chk("t6b_done_a", done_t[0], t0 + 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
